// File: rtl/pool_stream_unit.sv
// Streaming KxK non-overlapping max/average pooling over a raster-order feature map.
// One pixel position (LANES channels) per input beat; one pooled pixel per window out.
module pool_stream_unit #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned LANES  = 4,
    parameter int unsigned FM_W   = 28,
    parameter int unsigned FM_H   = 28,
    parameter int unsigned POOL_K = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      pool_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      frame_done
);

    localparam int unsigned LOG_K = $clog2(POOL_K);
    localparam int unsigned SHIFT = 2 * LOG_K;
    localparam int unsigned ACC_W = DATA_W + SHIFT;
    localparam int unsigned NWIN  = FM_W / POOL_K;
    localparam int unsigned COL_W = (FM_W > 1) ? $clog2(FM_W) : 1;
    localparam int unsigned ROW_W = (FM_H > 1) ? $clog2(FM_H) : 1;
    localparam int unsigned IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int unsigned BUS_W = LANES * DATA_W;

    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic                    mode_q;
    logic                    last_q;
    logic signed [ACC_W-1:0] part [NWIN][LANES];

    logic                    accept_c;
    logic                    origin_c;
    logic                    first_c;
    logic                    done_c;
    logic                    last_win_c;
    logic                    avg_c;
    logic [IDX_W-1:0]        idx_c;
    logic signed [DATA_W-1:0] lane_in  [LANES];
    logic signed [ACC_W-1:0]  lane_ext [LANES];
    logic signed [ACC_W-1:0]  comb_val [LANES];
    logic signed [ACC_W-1:0]  shifted  [LANES];
    logic [BUS_W-1:0]        res_c;

    // Stalls come only from a pending output; clr swallows any beat offered with it.
    assign in_ready = rst_n & ~clr & (~out_valid | out_ready);
    assign accept_c = in_valid & in_ready;

    // Window position decode and per-lane combine of the incoming beat with its row partial.
    always_comb begin
        origin_c   = (col == '0) && (row == '0);
        first_c    = (col[LOG_K-1:0] == '0) && (row[LOG_K-1:0] == '0);
        done_c     = (&col[LOG_K-1:0]) && (&row[LOG_K-1:0]);
        last_win_c = (col == COL_W'(FM_W - 1)) && (row == ROW_W'(FM_H - 1));
        avg_c      = origin_c ? pool_mode : mode_q;
        idx_c      = IDX_W'(col >> LOG_K);
        res_c      = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_in[l]  = in_data[l*DATA_W +: DATA_W];
            lane_ext[l] = ACC_W'(lane_in[l]);
            if (first_c) begin
                comb_val[l] = lane_ext[l];
            end else if (avg_c) begin
                comb_val[l] = part[idx_c][l] + lane_ext[l];
            end else begin
                comb_val[l] = (lane_ext[l] > part[idx_c][l]) ? lane_ext[l] : part[idx_c][l];
            end
            // Arithmetic shift floors toward negative infinity.
            shifted[l] = comb_val[l] >>> SHIFT;
            res_c[l*DATA_W +: DATA_W] = avg_c ? shifted[l][DATA_W-1:0]
                                              : comb_val[l][DATA_W-1:0];
        end
    end

    // Raster position counters and frame-start mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (accept_c) begin
            if (origin_c) begin
                mode_q <= pool_mode;
            end
            if (col == COL_W'(FM_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(FM_H - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Row-partial buffer, one entry per window column per lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < int'(NWIN); w++) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    part[w][l] <= '0;
                end
            end
        end else if (clr) begin
            for (int w = 0; w < int'(NWIN); w++) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    part[w][l] <= '0;
                end
            end
        end else if (accept_c) begin
            for (int l = 0; l < int'(LANES); l++) begin
                part[idx_c][l] <= comb_val[l];
            end
        end
    end

    // Output holding register; a completion during a handshake reloads in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & last_q & ~clr;
            if (clr) begin
                out_valid <= 1'b0;
                last_q    <= 1'b0;
            end else if (accept_c && done_c) begin
                out_valid <= 1'b1;
                out_data  <= res_c;
                last_q    <= last_win_c;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Directed bench for pool_stream_unit on a 4x4 map, K=2, 4 lanes, with a
// reference model feeding an expected-output queue.
module tb_pool_stream_unit;

    localparam int unsigned DW = 20;
    localparam int unsigned NL = 4;
    localparam int unsigned BW = DW * NL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          pool_mode;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          frame_done;

    pool_stream_unit #(
        .DATA_W(DW), .LANES(NL), .FM_W(4), .FM_H(4), .POOL_K(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pool_mode(pool_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        bit            last;
        int            cyc;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    bit     seen   = 1'b0;
    bit     fd_exp = 1'b0;
    int     m_col  = 0;
    int     m_row  = 0;
    bit     m_mode = 1'b0;
    longint m_acc [2][NL];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pix(input int sel, input int i);
        int t[16];
        logic signed [DW-1:0] l0, l1, l2, l3;
        t  = '{-1, -2, 5, 7, -3, -3, 0, -8, 9, 10, -20, 19, 11, 12, -19, -20};
        l0 = (sel == 0) ? DW'(i + 1) : DW'(t[i]);
        l1 = DW'(-3 * (i + 1));
        l2 = (i % 2 == 1) ? 20'sh7FFFF : 20'sh80000;
        l3 = (i < 8) ? 20'sh80000 : 20'sh7FFFF;
        return {l3, l2, l1, l0};
    endfunction

    task automatic model_reset();
        m_col  = 0;
        m_row  = 0;
        m_mode = 1'b0;
        sb.delete();
        seen   = 1'b0;
        fd_exp = 1'b0;
    endtask

    // Reference model: integer max / floor-average per window, pushes expected outputs.
    task automatic model_beat(input logic [BW-1:0] d, input bit md, input int c);
        exp_t e;
        logic signed [DW-1:0] s;
        longint v, q;
        bit done;
        int w;
        if (m_col == 0 && m_row == 0) m_mode = md;
        done   = (m_col % 2 == 1) && (m_row % 2 == 1);
        w      = m_col / 2;
        e.data = '0;
        for (int l = 0; l < int'(NL); l++) begin
            s = d[l*DW +: DW];
            v = s;
            if (m_col % 2 == 0 && m_row % 2 == 0) m_acc[w][l] = v;
            else if (m_mode) m_acc[w][l] = m_acc[w][l] + v;
            else if (v > m_acc[w][l]) m_acc[w][l] = v;
            if (m_mode) begin
                q = m_acc[w][l] / 4;
                if ((m_acc[w][l] % 4) != 0 && m_acc[w][l] < 0) q = q - 1;
            end else begin
                q = m_acc[w][l];
            end
            e.data[l*DW +: DW] = DW'(q);
        end
        e.last = (m_col == 3 && m_row == 3);
        e.cyc  = c;
        if (done) sb.push_back(e);
        if (m_col == 3) begin
            m_col = 0;
            m_row = (m_row == 3) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [BW-1:0] d, input bit md);
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        pool_mode = md;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", BW'(in_ready), BW'(1));
        else model_beat(d, md, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int sel, input bit md0, input int tog, input bit md1,
                             input int first, input int last, input bit gaps);
        @(posedge clk);
        #1;
        for (int i = first; i <= last; i++) begin
            send(pix(sel, i), (i >= tog) ? md1 : md0);
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
        chk("queue_empty", BW'(sb.size()), BW'(0));
    endtask

    // Output monitor: data, latency and frame_done against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("frame_done", BW'(frame_done), BW'(fd_exp));
            fd_exp = 1'b0;
            if (out_valid) begin
                chk("unexpected_output", BW'(sb.size() > 0), BW'(1));
                if (sb.size() > 0) begin
                    if (!seen) begin
                        chk("latency_cycle", BW'(cyc), BW'(sb[0].cyc));
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        chk("out_data", out_data, sb[0].data);
                        fd_exp = sb[0].last;
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        pool_mode = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_frame_done", BW'(frame_done), BW'(0));
        chk("rst_in_ready", BW'(in_ready), BW'(0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", BW'(in_ready), BW'(1));

        // Max mode, then average mode, then a negative-valued average frame with gaps.
        run_frame(0, 1'b0, 99, 1'b0, 0, 15, 1'b0);
        drain();
        run_frame(0, 1'b1, 99, 1'b1, 0, 15, 1'b0);
        drain();
        run_frame(1, 1'b1, 99, 1'b1, 0, 15, 1'b1);
        drain();

        // Backpressure for 5 cycles once the first output is up.
        run_frame(0, 1'b0, 99, 1'b0, 0, 4, 1'b0);
        out_ready = 1'b0;
        fork
            run_frame(0, 1'b0, 99, 1'b0, 5, 15, 1'b0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_out_valid", BW'(out_valid), BW'(1));
                for (int k = 0; k < 5; k++) begin
                    chk("bp_hold_data", BW'(out_data[DW-1:0]), BW'(6));
                    chk("bp_in_ready", BW'(in_ready), BW'(0));
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Mode change mid-frame is ignored; the next frame picks it up.
        run_frame(0, 1'b0, 4, 1'b1, 0, 15, 1'b0);
        drain();
        run_frame(0, 1'b1, 99, 1'b1, 0, 15, 1'b0);
        drain();

        // clr after beat 7 with a beat offered alongside, then full replay.
        run_frame(0, 1'b0, 99, 1'b0, 0, 6, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = pix(0, 7);
        @(negedge clk);
        chk("clr_in_ready", BW'(in_ready), BW'(0));
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("clr_out_valid", BW'(out_valid), BW'(0));
        run_frame(0, 1'b0, 99, 1'b0, 0, 15, 1'b0);
        drain();

        // Async reset mid-frame with an output pending, then full replay.
        run_frame(0, 1'b1, 99, 1'b1, 0, 5, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pend_out_valid", BW'(out_valid), BW'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", BW'(out_valid), BW'(0));
        chk("mid_rst_out_data", out_data, '0);
        chk("mid_rst_in_ready", BW'(in_ready), BW'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_frame(0, 1'b0, 99, 1'b0, 0, 15, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pool_stream_unit.md
Name: pool_stream_unit

Overview:
- Streaming 2-D pooling engine for the CNN datapath. Successor to the fixed 4-input max-pool block.
- Accepts a raster-order feature map, one pixel position per beat, with LANES channels in parallel.
- Applies non-overlapping POOL_K x POOL_K windows (stride = POOL_K) in max or average mode.
- Emits one pooled pixel per window over a valid/ready interface. Sits between the conv/ReLU output and the next layer's IFM buffer.

Parameters:
- DATA_W, 20, signed two's-complement width of each channel sample, in and out.
- LANES, 4, channels processed in parallel per beat.
- FM_W, 28, feature-map width in pixels; must be a multiple of POOL_K.
- FM_H, 28, feature-map height in pixels; must be a multiple of POOL_K.
- POOL_K, 2, window size and stride; must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: aborts the current frame.
- pool_mode  in  1  0 = max, 1 = average; sampled at frame start only.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  pooled beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*DATA_W  pooled result, same lane packing as in_data.
- frame_done  out  1  one-cycle pulse when the last output of a frame is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following go to 0 — out_valid, out_data, frame_done, col/row counters, partial buffers, latched mode.
- in_ready is 0 while rst_n is low; otherwise in_ready = !out_valid || out_ready.
- Counters:
  - col runs 0..FM_W-1 and row runs 0..FM_H-1, advancing on each accepted beat.
  - col wraps to 0 and row increments; after the (FM_W-1, FM_H-1) beat both wrap to 0.
- Mode latch: pool_mode is captured on the accepted beat where col=0 and row=0. Changes mid-frame are ignored.
- Window accumulation:
  - Row-partial buffer: FM_W/POOL_K entries per lane, indexed by col/POOL_K.
  - Accumulator width: DATA_W + 2*log2(POOL_K) for average mode.
  - First beat of a window (col%K==0 and row%K==0) overwrites the entry. Later beats combine with the entry: max (signed compare) or add (sign-extended).
- Output:
  - On the beat that completes a window (col%K==K-1 and row%K==K-1), the combined result is registered into out_data and out_valid is set on the next edge. Latency is 1 cycle.
  - Average result = arithmetic right shift of the sum by 2*log2(POOL_K), i.e. floor toward negative infinity.
- Handshake:
  - out_valid and out_data hold stable until out_ready.
  - The same-cycle accept-and-reload case is supported: a new completion while out_valid && out_ready loads the new result with out_valid staying 1.
  - Any input stall is caused only by pending output.
- frame_done pulses in the cycle after the output of window (last col-window, last row-window) is accepted.
- clr: next edge behaves like reset for counters, partial buffers and out_valid; a pending output is dropped. An in_valid beat in the same cycle as clr is ignored (in_ready=0 that cycle).
- Mid-frame reset or clr: the next accepted beat is treated as (0,0).
- in_valid low: no state change except output drain.

Test Plan:
1. Max mode, FM_W=FM_H=4, K=2, LANES=1, input 1..16 raster, out_ready=1 → outputs 6, 8, 14, 16, each 1 cycle after beats 6, 8, 14, 16; frame_done once.
2. Average mode, same stream → outputs 3, 5, 11, 13 (sums 14, 22, 46, 54 shifted right by 2). Window {-1,-2,-3,-3} → -3 (floor of -9/4).
3. Backpressure: out_ready=0 for 5 cycles after the first output → out_data stays 6, in_ready=0, no beats lost; final sequence unchanged.
4. Mode toggled at beat 5 of a max-mode frame → all four outputs still max; the next frame uses the new mode.
5. clr asserted after beat 7, then the full 16-beat frame replayed → exactly 4 outputs matching scenario 1; no stale partial. rst_n pulsed mid-frame gives the same.
6. LANES=4 with distinct per-lane ramps plus signed extremes (-2^19, 2^19-1) → per-lane independent max/avg with no overflow.
